logic_unit_seq: RTL and testbench
=================================

// Module: logic_unit_seq
// PURPOSE
//   Parametrised, multi-cycle bitwise logic unit for the datapath ALU.
//   Computes OR/AND/XOR/NOR of two WIDTH-bit operands one SLICE-bit slice per
//   clock, LSB slice first, under a start/busy/done handshake.
//   Result and zero flag are registered. Operands are latched at start, so
//   upstream may change them while the unit is busy.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be >= 1
//   SLICE   4  bits processed per cycle; WIDTH % SLICE must be 0
//              N = WIDTH/SLICE slices; SLICE == WIDTH gives N = 1
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   rst_n   in   1      synchronous, active-low reset
//   start   in   1      request; sampled only in IDLE or DONE
//   op      in   2      00 OR, 01 AND, 10 XOR, 11 NOR; latched with operands
//   input1  in   WIDTH  operand A; latched when start is accepted
//   input2  in   WIDTH  operand B; latched when start is accepted
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse: s/zero just updated
//   s       out  WIDTH  result; held until the next completion
//   zero    out  1      1 when s == 0; held with s
// BEHAVIOUR
//   Reset: rst_n low at a clk edge -> state IDLE, busy 0, done 0, s 0,
//     zero 1, slice counter 0, operand latches 0. Takes priority over all.
//   FSM states: IDLE, RUN, DONE (registered state, counter cnt 0..N-1).
//   IDLE -> RUN: start = 1 at an edge. Latch input1, input2 and op; cnt <= 0.
//   RUN: each edge computes slice cnt (bits cnt*SLICE +: SLICE) into a shadow
//     register; cnt increments.
//     - cnt == N-1 -> DONE; shadow -> s, zero <= (full result == 0).
//     - start is ignored in RUN; latched operands are unaffected.
//   DONE: done = 1 and busy = 0 for exactly one cycle.
//     - start = 1 -> RUN with new operands (back-to-back, no idle gap).
//     - otherwise -> IDLE.
//   Latency: start sampled at edge E0 -> busy high from E0 for N cycles.
//     - done high for the cycle after edge E0+N; s valid from that edge.
//   s/zero change only on the RUN->DONE edge or on reset; never partial slices.
//   Outputs are registered; no combinational path from inputs to outputs.
//   Reset mid-RUN: abort, no done pulse, outputs take reset values.
//   N = 1: RUN lasts one cycle; done one cycle after that.
//   Illegal parameter combination (WIDTH % SLICE != 0): elaboration error
//     via a generate-time check.
// TESTING (WIDTH=16, SLICE=4, N=4)
//   1. Reset: rst_n low 2 cycles, start = 1 -> busy 0, done 0, s 0x0000, zero 1.
//   2. OR: 0x00F0 | 0x0F0F (op 00) -> busy 4 cycles; done pulse 1 cycle;
//      s 0x0FFF, zero 0.
//   3. NOR: 0xFFFF, 0x0000 (op 11) -> s 0x0000, zero 1.
//      XOR: 0xAAAA ^ 0x5555 (op 10) -> s 0xFFFF, zero 0.
//      AND: 0xF0F0 & 0x3C3C (op 01) -> s 0x3030.
//   4. Hold: start AND 0x1234 & 0xFF00. During RUN, drive start = 1 and new
//      operands 0x0000. Required: result 0x1200, exactly one done pulse.
//   5. Back-to-back: start = 1 in the DONE cycle with OR 0x0001 | 0x8000.
//      Required: busy next cycle; second done 5 cycles after the first;
//      s 0x8001.
//   6. Reset mid-run: rst_n low on the 2nd RUN cycle. Required: busy 0,
//      no done, s 0x0000, zero 1. A following OR 0x00FF | 0xFF00 gives
//      s 0xFFFF.

Source files
------------

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle sliced OR/AND/XOR/NOR unit with start/busy/done handshake
module logic_unit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             zero
);
  localparam int N = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_params
    $error("logic_unit_seq: WIDTH must be >= 1 and a multiple of SLICE");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, shadow, shadow_nxt;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic last, accept;
  assign last = cnt == CW'(N - 1);
  assign accept = start && state != RUN;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_comb state_nxt = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_comb begin
    a_sl = a_q[int'(cnt)*SLICE +: SLICE];
    b_sl = b_q[int'(cnt)*SLICE +: SLICE];
    r_sl = op_q == 2'b00 ? a_sl | b_sl :
           op_q == 2'b01 ? a_sl & b_sl :
           op_q == 2'b10 ? a_sl ^ b_sl : ~(a_sl | b_sl);
    shadow_nxt = shadow;
    shadow_nxt[int'(cnt)*SLICE +: SLICE] = r_sl;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      shadow <= '0;
      s <= '0;
      zero <= 1'b1;
    end else if (accept) begin
      cnt <= '0;
      op_q <= op;
      a_q <= input1;
      b_q <= input2;
    end else if (state == RUN) begin
      shadow <= shadow_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        s <= shadow_nxt;
        zero <= shadow_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: scoreboard bench for logic_unit_seq (WIDTH=16, SLICE=4)
module tb_logic_unit_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [15:0] input1 = '0, input2 = '0;
  logic busy, done, zero;
  logic [15:0] s;
  int tests = 0, fails = 0, done_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic_unit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .input1(input1), .input2(input2),
    .busy(busy), .done(done), .s(s), .zero(zero)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    r = o == 2'b00 ? a | b : o == 2'b01 ? a & b : o == 2'b10 ? a ^ b : ~(a | b);
    return {r == 16'h0, r};
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done=1 s=%h, required no pending result", s);
      end else begin
        exp_v = exp_q.pop_front();
        if ({zero, s} !== exp_v) begin
          fails++;
          $display("FAIL scoreboard: got zero=%b s=%h, required zero=%b s=%h", zero, s, exp_v[16], exp_v[15:0]);
        end
      end
    end
  end
  task automatic drive_start(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    op = o;
    input1 = a;
    input2 = b;
    start = 1'b1;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bc++;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    if (s !== 16'h0000) begin fails++; $display("FAIL reset_s: got %h, required 0000", s); end
    if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b, required 1", zero); end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_or;
    int bc;
    bit ok;
    drive_start(2'b00, 16'h00F0, 16'h0F0F);
    wait_done(bc, ok);
    tests += 4;
    if (!ok) begin fails++; $display("FAIL or_timeout: got no done, required done"); end
    if (bc != 4) begin fails++; $display("FAIL or_busy_cycles: got %0d, required 4", bc); end
    if (s !== 16'h0FFF || zero !== 1'b0) begin fails++; $display("FAIL or_result: got s=%h zero=%b, required 0fff 0", s, zero); end
    if (busy !== 1'b0) begin fails++; $display("FAIL or_busy_in_done: got %b, required 0", busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL or_done_width: got done=%b, required 0", done); end
  endtask
  task automatic test_ops;
    int bc;
    bit ok;
    logic [1:0] ops[3] = '{2'b11, 2'b10, 2'b01};
    logic [15:0] as[3] = '{16'hFFFF, 16'hAAAA, 16'hF0F0};
    logic [15:0] bs[3] = '{16'h0000, 16'h5555, 16'h3C3C};
    logic [15:0] rs[3] = '{16'h0000, 16'hFFFF, 16'h3030};
    logic zs[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_start(ops[i], as[i], bs[i]);
      wait_done(bc, ok);
      tests++;
      if (!ok || s !== rs[i] || zero !== zs[i]) begin
        fails++;
        $display("FAIL op%0d_result: got done=%b s=%h zero=%b, required 1 %h %b", i, ok, s, zero, rs[i], zs[i]);
      end
    end
  endtask
  task automatic test_hold;
    int bc, d0;
    bit ok;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    drive_start(2'b01, 16'h1234, 16'hFF00);
    start = 1'b1;
    input1 = 16'h0000;
    input2 = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(bc, ok);
    repeat (6) @(negedge clk);
    tests += 2;
    if (!ok || s !== 16'h1200) begin fails++; $display("FAIL hold_result: got done=%b s=%h, required 1 1200", ok, s); end
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL hold_done_count: got %0d, required 1", done_cnt - d0); end
  endtask
  task automatic test_back_to_back;
    int bc, gap;
    bit ok;
    drive_start(2'b10, 16'h00FF, 16'h0F0F);
    wait_done(bc, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_first_timeout: got no done, required done"); end
    op = 2'b00;
    input1 = 16'h0001;
    input2 = 16'h8000;
    start = 1'b1;
    exp_q.push_back(model(2'b00, 16'h0001, 16'h8000));
    @(posedge clk);
    #1 start = 1'b0;
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (gap == 1) begin
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_next: got %b, required 1", busy); end
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tests += 2;
    if (!ok || gap != 5) begin fails++; $display("FAIL b2b_gap: got done=%b gap=%0d, required 1 5", ok, gap); end
    if (s !== 16'h8001) begin fails++; $display("FAIL b2b_result: got %h, required 8001", s); end
  endtask
  task automatic test_reset_mid;
    int bc, d0;
    bit ok;
    @(negedge clk);
    d0 = done_cnt;
    op = 2'b00;
    input1 = 16'h1234;
    input2 = 16'h4321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests += 3;
    if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_flags: got busy=%b done=%b, required 0 0", busy, done); end
    if (s !== 16'h0000 || zero !== 1'b1) begin fails++; $display("FAIL midrst_outputs: got s=%h zero=%b, required 0000 1", s, zero); end
    repeat (8) @(negedge clk);
    if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses, required 0", done_cnt - d0); end
    drive_start(2'b00, 16'h00FF, 16'hFF00);
    wait_done(bc, ok);
    tests++;
    if (!ok || s !== 16'hFFFF || zero !== 1'b0) begin fails++; $display("FAIL midrst_after: got done=%b s=%h zero=%b, required 1 ffff 0", ok, s, zero); end
  endtask
  initial begin
    test_reset;
    test_or;
    test_ops;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
